// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard control FSM with status capture and saturating event counters
// Counters are CntW bits wide (default 32), zero-extended onto the 32-bit count outputs.
module pipe_ctrl #(
   parameter int CntW = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  M_icode,
   input  logic [3:0]  W_icode,
   input  logic [3:0]  E_dstM,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic        e_Cnd,
   input  logic [1:0]  m_stat,
   input  logic [1:0]  W_stat,
   output logic        F_stall,
   output logic        D_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        M_bubble,
   output logic        W_stall,
   output logic        set_cc,
   output logic [1:0]  cpu_stat,
   output logic        halted,
   output logic [31:0] cyc_cnt,
   output logic [31:0] ret_cnt,
   output logic [31:0] lu_cnt,
   output logic [31:0] mp_cnt
);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_ADR = 2'd2;
   localparam logic [1:0] S_INS = 2'd3;

   typedef enum logic [1:0] {stIdle, stRun, stHalted, stError} state_t;

   state_t state, nextState;

   logic loadUse, retIn, misPred;
   logic [1:0] cpuStatQ;
   logic haltedQ;
   logic [CntW-1:0] cycQ, retQ, luQ, mpQ;

   function automatic logic [CntW-1:0] satInc(input logic [CntW-1:0] v);
      return (&v) ? v : v + CntW'(1);
   endfunction

   // Hazard terms from the stage registers
   assign loadUse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign retIn   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign misPred = (E_icode == I_JXX) && !e_Cnd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= stIdle;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         stIdle: if (start) nextState = stRun;
         stRun: begin
            if (W_stat == S_HLT)                          nextState = stHalted;
            else if ((W_stat == S_ADR) || (W_stat == S_INS)) nextState = stError;
         end
         default: nextState = state;
      endcase
   end

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
      case (state)
         stIdle: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
         stRun: begin
            F_stall  = loadUse || retIn;
            D_stall  = loadUse;
            D_bubble = misPred || (retIn && !loadUse);
            E_bubble = misPred || loadUse;
            M_bubble = (m_stat != S_AOK) || (W_stat != S_AOK);
            W_stall  = (W_stat != S_AOK);
            set_cc   = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);
         end
         default: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
         end
      endcase
   end

   // Status is latched only on the RUN exit edge; HALTED/ERROR leave by reset alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpuStatQ <= S_AOK;
         haltedQ  <= 1'b0;
      end else begin
         if ((state == stRun) && (W_stat != S_AOK)) cpuStatQ <= W_stat;
         haltedQ <= (nextState == stHalted) || (nextState == stError);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycQ <= '0;
         retQ <= '0;
         luQ  <= '0;
         mpQ  <= '0;
      end else if (state == stRun) begin
         cycQ <= satInc(cycQ);
         if ((W_stat == S_AOK) && (W_icode != I_NOP)) retQ <= satInc(retQ);
         if (loadUse) luQ <= satInc(luQ);
         if (misPred) mpQ <= satInc(mpQ);
      end
   end

   assign cpu_stat = cpuStatQ;
   assign halted   = haltedQ;
   assign cyc_cnt  = 32'(cycQ);
   assign ret_cnt  = 32'(retQ);
   assign lu_cnt   = 32'(luQ);
   assign mp_cnt   = 32'(mpQ);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
// Built with 8-bit counters so the saturation boundary is reachable by real retirements.
module tb_pipe_ctrl;

   localparam int CW = 8;
   localparam logic [31:0] CAP = 32'h0000_00FF;
   localparam logic [6:0] C_IDLE = 7'b1011100;
   localparam logic [6:0] C_STOP = 7'b1100110;
   localparam logic [6:0] C_NONE = 7'b0000000;

   logic clk, rst_n, start;
   logic [3:0] D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB;
   logic e_Cnd;
   logic [1:0] m_stat, W_stat;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
   logic [1:0] cpu_stat;
   logic halted;
   logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

   pipe_ctrl #(.CntW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
      .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
      .cpu_stat(cpu_stat), .halted(halted),
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [6:0] sbQ[$];
   logic [31:0] eCyc, eRet, eLu, eMp;
   bit eRun;
   logic [6:0] ctl;

   assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == CAP) ? v : v + 32'd1;
   endfunction

   task automatic nopIns();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b1;
      m_stat = 2'd0; W_stat = 2'd0; start = 1'b0;
   endtask

   task automatic chkCnt(input string tag);
      chk({tag, ":cyc"}, cyc_cnt, eCyc);
      chk({tag, ":ret"}, ret_cnt, eRet);
      chk({tag, ":lu"},  lu_cnt,  eLu);
      chk({tag, ":mp"},  mp_cnt,  eMp);
   endtask

   task automatic chkStat(input string tag, input logic [1:0] st, input logic h);
      chk({tag, ":cpu_stat"}, 32'(cpu_stat), 32'(st));
      chk({tag, ":halted"}, 32'(halted), 32'(h));
   endtask

   // Called with inputs already applied at the falling edge
   task automatic step(input logic [6:0] expCtl, input bit r, input bit lu, input bit mp,
                       input string tag);
      logic [6:0] want;
      sbQ.push_back(expCtl);
      #1;
      want = sbQ.pop_front();
      chk({tag, ":ctl"}, 32'(ctl), 32'(want));
      @(posedge clk);
      #1;
      if (eRun) begin
         eCyc = sat(eCyc);
         if (r)  eRet = sat(eRet);
         if (lu) eLu = sat(eLu);
         if (mp) eMp = sat(eMp);
      end
      chkCnt(tag);
      @(negedge clk);
   endtask

   task automatic chkReset(input string tag);
      eCyc = 0; eRet = 0; eLu = 0; eMp = 0; eRun = 1'b0;
      chk({tag, ":ctl"}, 32'(ctl), 32'(C_IDLE));
      chkCnt(tag);
      chkStat(tag, 2'd0, 1'b0);
   endtask

   initial begin
      nopIns();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 chkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step(C_IDLE, 0, 0, 0, "idle");
      start = 1'b1;
      step(C_IDLE, 0, 0, 0, "start");
      start = 1'b0; eRun = 1'b1;
      chkStat("run", 2'd0, 1'b0);
      step(C_NONE, 0, 0, 0, "run0");
      step(C_NONE, 0, 0, 0, "run1");

      E_icode = 4'h6; W_icode = 4'h6;
      step(7'b0000001, 1, 0, 0, "retire_opq");
      nopIns();
      E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
      step(7'b1101000, 0, 1, 0, "loaduse");
      E_dstM = 4'hF;
      step(C_NONE, 0, 0, 0, "lu_none");
      nopIns();
      E_icode = 4'h7; e_Cnd = 1'b0;
      step(7'b0011000, 0, 0, 1, "mispred");
      e_Cnd = 1'b1;
      step(C_NONE, 0, 0, 0, "jxx_taken");
      nopIns();
      D_icode = 4'h9;
      step(7'b1010000, 0, 0, 0, "ret_d");
      nopIns();
      E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4; D_icode = 4'h9;
      step(7'b1101000, 0, 1, 0, "lu_ret");
      nopIns();

      E_icode = 4'h6; m_stat = 2'd2;
      step(7'b0000100, 0, 0, 0, "mstat_adr");
      nopIns();
      W_stat = 2'd2; W_icode = 4'h6;
      step(7'b0000110, 0, 0, 0, "wstat_adr");
      eRun = 1'b0;
      chkStat("error", 2'd2, 1'b1);
      nopIns();
      E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; W_icode = 4'h6; start = 1'b1;
      step(C_STOP, 0, 0, 0, "err_hold");
      chkStat("err_hold", 2'd2, 1'b1);

      nopIns();
      #2 rst_n = 1'b0;
      #1 chkReset("rst_err");
      @(negedge clk);
      rst_n = 1'b1;
      step(C_IDLE, 0, 0, 0, "post_rst0");
      step(C_IDLE, 0, 0, 0, "post_rst1");

      start = 1'b1;
      step(C_IDLE, 0, 0, 0, "start2");
      start = 1'b0; eRun = 1'b1;
      W_icode = 4'h6;
      step(C_NONE, 1, 0, 0, "retire2");
      W_icode = 4'h0; W_stat = 2'd1;
      step(7'b0000110, 0, 0, 0, "halt_w");
      eRun = 1'b0;
      chkStat("halted", 2'd1, 1'b1);
      nopIns();
      start = 1'b1;
      step(C_STOP, 0, 0, 0, "halt_start");
      start = 1'b0;
      step(C_STOP, 0, 0, 0, "halt_hold");
      chkStat("halt_hold", 2'd1, 1'b1);

      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chkReset("rst_halt");
      @(negedge clk);
      rst_n = 1'b1;

      start = 1'b1;
      step(C_IDLE, 0, 0, 0, "start3");
      start = 1'b0; eRun = 1'b1;
      W_icode = 4'h6;
      repeat (254) step(C_NONE, 1, 0, 0, "ret_fill");
      chk("ret_preload", ret_cnt, 32'h0000_00FE);
      repeat (3) step(C_NONE, 1, 0, 0, "ret_sat");
      chk("ret_saturated", ret_cnt, CAP);
      chk("cyc_saturated", cyc_cnt, CAP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle pulse; leaves IDLE and begins execution.
REQ-004 D_icode, E_icode, M_icode, W_icode  in  4 each  icodes at the D/E/M/W stage registers.
REQ-005 E_dstM  in  4  E-stage memory destination register; 4'hF = none.
REQ-006 d_srcA, d_srcB  in  4 each  decode-stage source registers; 4'hF = none.
REQ-007 e_Cnd  in  1  execute-stage branch condition.
REQ-008 m_stat, W_stat  in  2 each  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-009 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc  out  1 each  pipeline control signals.
REQ-010 cpu_stat  out  2  registered architectural status.
REQ-011 halted  out  1  registered; high in HALTED or ERROR.
REQ-012 cyc_cnt, ret_cnt, lu_cnt, mp_cnt  out  32 each  registered cycle, retired, load-use and mispredict counters.

Function
REQ-013 Icode constants: HALT 0, NOP 1, OPQ 6, JXX 7, RET 9, MRMOVQ 5, POPQ B.
REQ-014 States: IDLE, RUN, HALTED, ERROR; the state register updates on posedge clk.
REQ-015 In IDLE: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1; D_stall=0, W_stall=0, set_cc=0.
REQ-016 IDLE->RUN when start=1; start is ignored in every other state.
REQ-017 load_use = E_icode in {MRMOVQ,POPQ} AND E_dstM != 4'hF AND E_dstM in {d_srcA,d_srcB}.
REQ-018 ret_in = RET in {D_icode,E_icode,M_icode}; mispred = E_icode==JXX AND e_Cnd==0.
REQ-019 In RUN: F_stall = load_use OR ret_in; D_stall = load_use.
REQ-020 In RUN: D_bubble = mispred OR (ret_in AND NOT load_use); E_bubble = mispred OR load_use.
REQ-021 In RUN: M_bubble = (m_stat != AOK) OR (W_stat != AOK); W_stall = (W_stat != AOK).
REQ-022 In RUN: set_cc = (E_icode==OPQ) AND m_stat==AOK AND W_stat==AOK.
REQ-023 All control outputs are combinational from state and inputs, valid in the same cycle.
REQ-024 RUN->HALTED when W_stat==HLT; RUN->ERROR when W_stat is ADR or INS; cpu_stat captures W_stat on that edge.
REQ-025 In HALTED/ERROR: F_stall=1, D_stall=1, W_stall=1, M_bubble=1; D_bubble=0, E_bubble=0, set_cc=0; exit is by reset only.
REQ-026 cpu_stat = AOK in IDLE and RUN.
REQ-027 cyc_cnt increments on every RUN cycle.
REQ-028 ret_cnt increments on each RUN cycle with W_stat==AOK AND W_icode != NOP; the HALT instruction reaching W is not counted.
REQ-029 lu_cnt increments on each RUN cycle with load_use=1; mp_cnt increments on each RUN cycle with mispred=1.
REQ-030 All counters saturate at 32'hFFFFFFFF (no wrap) and hold in IDLE, HALTED and ERROR.
REQ-031 When load_use and mispred are both true: F_stall=1, D_stall=1, E_bubble=1, D_bubble=1; both lu_cnt and mp_cnt increment.

Reset
REQ-032 rst_n=0 asynchronously forces state=IDLE, cpu_stat=0, halted=0 and all counters to 0, independent of clk.
REQ-033 Reset asserted mid-RUN aborts immediately; after release, the block stays in IDLE until start.

Verification
REQ-034 Reset, then start pulse: cycle 0 in IDLE shows F_stall=1 and all bubbles=1; after start, state is RUN and cyc_cnt increments by 1 per clk.
REQ-035 E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, lu_cnt+1; with E_dstM=F -> all four signals 0.
REQ-036 E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0, mp_cnt+1; D_icode=9 alone -> F_stall=1, D_bubble=1.
REQ-037 E_icode=6, m_stat=2 -> set_cc=0, M_bubble=1; next cycle W_stat=2 -> W_stall=1, state ERROR, cpu_stat=2, halted=1, counters frozen.
REQ-038 W_icode=0, W_stat=1 -> HALTED, cpu_stat=1, ret_cnt unchanged; subsequent start pulses have no effect; rst_n low mid-cycle clears all outputs at once.
REQ-039 Preload ret_cnt to 32'hFFFFFFFE via a run of retirements, then apply 3 more retirements -> ret_cnt holds at 32'hFFFFFFFF.
